// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select with bounded burst ownership.
// All outputs are registered; the winner search rotates from the last owner on release.
module rr_mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [1:0] base;
  logic [1:0] cand;
  logic [1:0] win;
  logic       found;
  logic       keep;

  // On release the search starts just past the owner, so the owner is checked last.
  always_comb begin
    base  = (state_q == StGrant) ? sel_q + 2'd1 : ptr_q;
    cand  = base;
    win   = base;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand = base + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign keep = (state_q == StGrant) && req[sel_q] && (hold_q < MaxHold);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    if (keep) begin
      hold_d = hold_q + CNT_W'(1);
    end else begin
      if (state_q == StGrant) begin
        ptr_d = sel_q + 2'd1;
      end
      if (found) begin
        state_d = StGrant;
        sel_d   = win;
        gnt_d   = 4'b0001 << win;
        valid_d = 1'b1;
        hold_d  = CNT_W'(1);
      end else begin
        // sel keeps the last owner's index while idle.
        state_d = StIdle;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign valid    = valid_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Scoreboard bench: directed vectors push expected outputs, a monitor pops and compares.
// Two instances cover MAX_HOLD=8 and MAX_HOLD=1.
module tb_rr_mux_sel_arbiter;

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] hold;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req1;

  logic [1:0] sel8, sel1;
  logic [3:0] gnt8, gnt1;
  logic       valid8, valid1;
  logic [3:0] hold8, hold1;

  exp_t q8[$];
  exp_t q1[$];
  int   total;
  int   bad;

  rr_mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .sel      (sel8),
    .gnt      (gnt8),
    .valid    (valid8),
    .hold_cnt (hold8)
  );

  rr_mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req1),
    .sel      (sel1),
    .gnt      (gnt1),
    .valid    (valid1),
    .hold_cnt (hold1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input string n, input int s, input int g, input int v, input int h);
    exp_t e;
    e.name  = n;
    e.sel   = 2'(s);
    e.gnt   = 4'(g);
    e.valid = 1'(v);
    e.hold  = 4'(h);
    return e;
  endfunction

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst_n = r;
    req   = a;
    req1  = b;
  endtask

  // Monitor: one expected entry per cycle, compared after the active edge.
  exp_t e8;
  exp_t e1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        total++;
        if (sel8 !== e8.sel || gnt8 !== e8.gnt || valid8 !== e8.valid || hold8 !== e8.hold) begin
          bad++;
          $display("FAIL %s: got sel=%0d gnt=%b valid=%b hold=%0d, want sel=%0d gnt=%b valid=%b hold=%0d",
                   e8.name, sel8, gnt8, valid8, hold8, e8.sel, e8.gnt, e8.valid, e8.hold);
        end
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        total++;
        if (sel1 !== e1.sel || gnt1 !== e1.gnt || valid1 !== e1.valid || hold1 !== e1.hold) begin
          bad++;
          $display("FAIL %s: got sel=%0d gnt=%b valid=%b hold=%0d, want sel=%0d gnt=%b valid=%b hold=%0d",
                   e1.name, sel1, gnt1, valid1, hold1, e1.sel, e1.gnt, e1.valid, e1.hold);
        end
      end
    end
  end

  int owners[5] = '{0, 1, 2, 3, 0};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    req1  = 4'b0000;

    // Reset, then idle with no requests.
    drive(1'b0, 4'b0000, 4'b0000); q8.push_back(ex("reset", 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'b0000, 4'b0000); q8.push_back(ex("idle", 0, 0, 0, 0));
    end

    // Sole requester 2: holds 8 cycles then is re-granted.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 4'b0100, 4'b0000); q8.push_back(ex("sole_hold", 2, 4'b0100, 1, k));
    end
    drive(1'b1, 4'b0100, 4'b0000); q8.push_back(ex("sole_regrant", 2, 4'b0100, 1, 1));
    drive(1'b0, 4'b0100, 4'b0000); q8.push_back(ex("reset2", 0, 0, 0, 0));

    // All requesting: strict rotation, 8 cycles each, no bubbles.
    for (int o = 0; o < 5; o++) begin
      for (int k = 1; k <= 8; k++) begin
        drive(1'b1, 4'b1111, 4'b0000);
        q8.push_back(ex("rotate", owners[o], 1 << owners[o], 1, k));
      end
    end
    drive(1'b0, 4'b0000, 4'b0000); q8.push_back(ex("reset3", 0, 0, 0, 0));

    // Owner 1 drops at hold 3 with req=1001 -> hand-off to 3, then idle keeps sel.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 4'b0010, 4'b0000); q8.push_back(ex("own1", 1, 4'b0010, 1, k));
    end
    drive(1'b1, 4'b1001, 4'b0000); q8.push_back(ex("handoff3", 3, 4'b1000, 1, 1));
    drive(1'b1, 4'b0000, 4'b0000); q8.push_back(ex("idle_sel3", 3, 0, 0, 0));
    drive(1'b1, 4'b0000, 4'b0000); q8.push_back(ex("idle_sel3b", 3, 0, 0, 0));

    // Reset mid-grant, then search restarts from pointer 0.
    drive(1'b0, 4'b0000, 4'b0000); q8.push_back(ex("reset4", 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'b0100, 4'b0000); q8.push_back(ex("own2", 2, 4'b0100, 1, k));
    end
    drive(1'b0, 4'b0110, 4'b0000); q8.push_back(ex("reset_mid", 0, 0, 0, 0));
    drive(1'b1, 4'b0110, 4'b0000); q8.push_back(ex("post_reset", 1, 4'b0010, 1, 1));

    // MAX_HOLD=1 instance: alternates every cycle.
    drive(1'b0, 4'b0000, 4'b0000); q1.push_back(ex("mh1_reset", 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 4'b0000, 4'b0101);
      if (k % 2 == 0) q1.push_back(ex("mh1_alt", 0, 4'b0001, 1, 1));
      else            q1.push_back(ex("mh1_alt", 2, 4'b0100, 1, 1));
    end
    drive(1'b1, 4'b0000, 4'b0000); q1.push_back(ex("mh1_idle", 2, 0, 0, 0));

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q8.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", q8.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
